// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: program-memory read port plus decoded-instruction handshake.
// Latency: none, wires only.
// Backpressure: instr_ready from the consumer holds the presented fields in place.
interface instruction_fetch_if;
    logic [4:0]  instruction_address;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [1:0]  reg_sel;
    logic [9:0]  operand;

    // Fetch unit side: drives address and decoded fields, reads memory data and ready.
    modport master (
        output instruction_address, instr_valid, opcode, reg_sel, operand,
        input  instruction, instr_ready
    );

    // Memory/consumer side.
    modport slave (
        input  instruction_address, instr_valid, opcode, reg_sel, operand,
        output instruction, instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Sequential instruction fetcher: reads program memory at pc and presents decoded fields.
// Latency: start to first instr_valid is 2 cycles; one instruction per 2 cycles with ready high.
// Backpressure: fields held stable in PRESENT until instr_valid && instr_ready.
// Optional: define FETCH_NOP_SKIP_EN to drop opcode 4'hF (NOP) in FETCH without presenting it.
module instruction_fetch #(
    parameter int LAST_ADDR = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                flush,
    output logic                halted,
    instruction_fetch_if.master bus
);
    localparam logic [4:0] LAST_PC = 5'(LAST_ADDR);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HALT} state_t;

    state_t      state, state_nxt;
    logic [4:0]  pc, pc_nxt;
    logic        last_flag, last_flag_nxt;
    logic [15:0] ir, ir_nxt;
    logic        is_nop;

`ifdef FETCH_NOP_SKIP_EN
    assign is_nop = (bus.instruction[15:12] == 4'hF);
`else
    assign is_nop = 1'b0;
`endif

    // State, program counter and instruction register; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= 5'd0;
            last_flag <= 1'b0;
            ir        <= 16'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            last_flag <= last_flag_nxt;
            ir        <= ir_nxt;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        last_flag_nxt = last_flag;
        ir_nxt        = ir;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                pc_nxt = pc + 5'd1;
                if (is_nop) begin
                    // NOP is consumed here; the end of program can still be reached through it.
                    state_nxt = (pc == LAST_PC) ? HALT : FETCH;
                end else begin
                    ir_nxt        = bus.instruction;
                    last_flag_nxt = (pc == LAST_PC);
                    state_nxt     = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.instr_ready) state_nxt = last_flag ? HALT : FETCH;
            end
            HALT: begin
                if (start) begin
                    pc_nxt    = 5'd0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt     = IDLE;
            pc_nxt        = 5'd0;
            last_flag_nxt = 1'b0;
        end
    end

    // Outputs are pure functions of state, so halted and instr_valid are mutually exclusive.
    always_comb begin
        bus.instruction_address = pc;
        bus.instr_valid         = (state == PRESENT);
        halted                  = (state == HALT);
        bus.opcode              = ir[15:12];
        bus.reg_sel             = ir[11:10];
        bus.operand             = ir[9:0];
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (LAST_ADDR 31 and 3) fed from random program images.
// Latency: checks start-to-valid and per-instruction cycle cost against a program-order model.
// Backpressure: stalls the consumer and randomizes instr_ready.
module tb_instruction_fetch;
`ifdef FETCH_NOP_SKIP_EN
    localparam bit NOP_SKIP = 1'b1;
`else
    localparam bit NOP_SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start_a, flush_a, halted_a;
    logic start_b, flush_b, halted_b;
    logic [15:0] mem_a [32];
    logic [15:0] mem_b [32];

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_data [$];
    logic [4:0]  exp_addr [$];
    int          exp_cycles;

    instruction_fetch_if bus_a ();
    instruction_fetch_if bus_b ();

    assign bus_a.instruction = mem_a[bus_a.instruction_address];
    assign bus_b.instruction = mem_b[bus_b.instruction_address];

    instruction_fetch #(.LAST_ADDR(31)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .flush(flush_a), .halted(halted_a), .bus(bus_a)
    );
    instruction_fetch #(.LAST_ADDR(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .flush(flush_b), .halted(halted_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_word(input bit allow_nop);
        logic [15:0] w;
        w = 16'($urandom);
        if (!allow_nop && w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
        return w;
    endfunction

    // Expected presentation order: every address 0..last in turn, NOPs dropped when skipping.
    function automatic void build_model(input bit which, input int last);
        logic [15:0] w;
        exp_data.delete();
        exp_addr.delete();
        exp_cycles = 0;
        for (int a = 0; a <= last; a++) begin
            w = which ? mem_b[a] : mem_a[a];
            if (NOP_SKIP && w[15:12] == 4'hF) begin
                exp_cycles += 1;
            end else begin
                exp_data.push_back(w);
                exp_addr.push_back(5'(a));
                exp_cycles += 2;
            end
        end
    endfunction

    task automatic do_reset();
        start_a = 0; flush_a = 0; bus_a.instr_ready = 0;
        start_b = 0; flush_b = 0; bus_b.instr_ready = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        start_a = 0; flush_a = 0; bus_a.instr_ready = 0;
        start_b = 0; flush_b = 0; bus_b.instr_ready = 0;
        rst = 1'b1;
        #2;
        checks++;
        if ({bus_a.instr_valid, halted_a, bus_a.instruction_address, bus_a.opcode, bus_a.reg_sel, bus_a.operand} !== 24'd0) begin
            errors++;
            $display("FAIL reset_a: outputs %h required 0", {bus_a.instr_valid, halted_a, bus_a.instruction_address, bus_a.opcode, bus_a.reg_sel, bus_a.operand});
        end
        checks++;
        if ({bus_b.instr_valid, halted_b, bus_b.instruction_address, bus_b.opcode, bus_b.reg_sel, bus_b.operand} !== 24'd0) begin
            errors++;
            $display("FAIL reset_b: outputs %h required 0", {bus_b.instr_valid, halted_b, bus_b.instruction_address, bus_b.opcode, bus_b.reg_sel, bus_b.operand});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus_a.instr_valid !== 1'b0 || bus_a.instruction_address !== 5'd0) begin
            errors++;
            $display("FAIL idle_hold: valid=%b addr=%0d required valid=0 addr=0", bus_a.instr_valid, bus_a.instruction_address);
        end
    endtask

    task automatic test_first_valid();
        int lat;
        do_reset();
        for (int a = 0; a < 32; a++) mem_a[a] = rand_word(0);
        mem_a[0] = 16'hF000;
        mem_a[1] = 16'h0000;
        bus_a.instr_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 1;
        while (bus_a.instr_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== (NOP_SKIP ? 3 : 2)) begin
            errors++;
            $display("FAIL first_latency: got %0d cycles required %0d", lat, NOP_SKIP ? 3 : 2);
        end
        checks++;
        if (bus_a.opcode !== (NOP_SKIP ? 4'h0 : 4'hF) || bus_a.instruction_address !== (NOP_SKIP ? 5'd2 : 5'd1)) begin
            errors++;
            $display("FAIL first_valid: opcode=%h addr=%0d required opcode=%h addr=%0d",
                     bus_a.opcode, bus_a.instruction_address, NOP_SKIP ? 4'h0 : 4'hF, NOP_SKIP ? 2 : 1);
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        for (int a = 0; a < 32; a++) mem_a[a] = rand_word(0);
        build_model(0, 31);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (bus_a.instr_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus_a.instr_valid !== 1'b1 || {bus_a.opcode, bus_a.reg_sel, bus_a.operand} !== exp_data[0]
                || bus_a.instruction_address !== exp_addr[0] + 5'd1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b fields=%h addr=%0d required valid=1 fields=%h addr=%0d", i,
                         bus_a.instr_valid, {bus_a.opcode, bus_a.reg_sel, bus_a.operand}, bus_a.instruction_address,
                         exp_data[0], exp_addr[0] + 5'd1);
            end
        end
        bus_a.instr_ready = 1'b1;
        tick();
        checks++;
        if (bus_a.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b required 0", bus_a.instr_valid);
        end
    endtask

    task automatic run_program_a(input string name, input bit rand_ready);
        int n, hs, n_exp_hs;
        bit done;
        logic [15:0] got;
        logic [4:0] paddr;
        build_model(0, 31);
        n_exp_hs = exp_data.size();
        bus_a.instr_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0; hs = 0; done = 1'b0;
        while (!done && n < 400) begin
            if (rand_ready) bus_a.instr_ready = 1'($urandom_range(0, 1));
            checks++;
            if (halted_a === 1'b1 && bus_a.instr_valid === 1'b1) begin
                errors++;
                $display("FAIL %s_exclusive: halted=1 instr_valid=1 at cycle %0d required not both", name, n);
            end
            if (bus_a.instr_valid === 1'b1 && bus_a.instr_ready === 1'b1) begin
                hs++;
                got = {bus_a.opcode, bus_a.reg_sel, bus_a.operand};
                paddr = bus_a.instruction_address - 5'd1;
                checks++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra: unexpected instruction %h at addr %0d", name, got, paddr);
                end else if (got !== exp_data[0] || paddr !== exp_addr[0]) begin
                    errors++;
                    $display("FAIL %s_data: got %h@%0d required %h@%0d", name, got, paddr, exp_data[0], exp_addr[0]);
                end
                if (exp_data.size() != 0) begin
                    exp_data.delete(0);
                    exp_addr.delete(0);
                end
            end
            if (halted_a === 1'b1) done = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: no halt after %0d cycles", name, n);
        end
        checks++;
        if (hs != n_exp_hs) begin
            errors++;
            $display("FAIL %s_count: got %0d handshakes required %0d", name, hs, n_exp_hs);
        end
        if (!rand_ready) begin
            checks++;
            if (n != exp_cycles) begin
                errors++;
                $display("FAIL %s_cycles: got %0d required %0d", name, n, exp_cycles);
            end
        end
        checks++;
        if (bus_a.instruction_address !== 5'd0 || halted_a !== 1'b1 || bus_a.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: addr=%0d halted=%b valid=%b required addr=0 halted=1 valid=0",
                     name, bus_a.instruction_address, halted_a, bus_a.instr_valid);
        end
    endtask

    task automatic test_full_run();
        do_reset();
        for (int a = 0; a < 32; a++) mem_a[a] = rand_word(0);
        run_program_a("full_run", 1'b0);
        // Restart straight from HALT with a NOP-rich image and a jittery consumer.
        for (int a = 0; a < 32; a++) mem_a[a] = ($urandom_range(0, 3) == 0) ? {4'hF, 12'($urandom)} : rand_word(0);
        mem_a[31] = {4'hF, 12'h0AB};
        run_program_a("random_run", 1'b1);
    endtask

    task automatic test_last_addr();
        int n, hs, n_exp_hs;
        do_reset();
        for (int a = 0; a < 32; a++) mem_b[a] = rand_word(0);
        build_model(1, 3);
        n_exp_hs = exp_data.size();
        bus_b.instr_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0; hs = 0;
        while (halted_b !== 1'b1 && n < 50) begin
            if (bus_b.instr_valid === 1'b1) begin
                hs++;
                checks++;
                if ({bus_b.opcode, bus_b.reg_sel, bus_b.operand} !== exp_data[0]) begin
                    errors++;
                    $display("FAIL last_data: got %h required %h", {bus_b.opcode, bus_b.reg_sel, bus_b.operand}, exp_data[0]);
                end
                exp_data.delete(0);
            end
            tick();
            n++;
        end
        checks++;
        if (hs != n_exp_hs || hs != 4) begin
            errors++;
            $display("FAIL last_count: got %0d handshakes required %0d", hs, n_exp_hs);
        end
        checks++;
        if (halted_b !== 1'b1 || bus_b.instruction_address !== 5'd4 || bus_b.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL last_halt: halted=%b addr=%0d valid=%b required halted=1 addr=4 valid=0",
                     halted_b, bus_b.instruction_address, bus_b.instr_valid);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++;
        if (bus_b.instruction_address !== 5'd0 || halted_b !== 1'b0) begin
            errors++;
            $display("FAIL restart: addr=%0d halted=%b required addr=0 halted=0", bus_b.instruction_address, halted_b);
        end
        tick();
        checks++;
        if (bus_b.instr_valid !== 1'b1 || {bus_b.opcode, bus_b.reg_sel, bus_b.operand} !== mem_b[0]) begin
            errors++;
            $display("FAIL restart_data: valid=%b fields=%h required valid=1 fields=%h",
                     bus_b.instr_valid, {bus_b.opcode, bus_b.reg_sel, bus_b.operand}, mem_b[0]);
        end
    endtask

    task automatic test_flush();
        int n;
        bit seen;
        do_reset();
        for (int a = 0; a < 32; a++) mem_a[a] = rand_word(0);
        // Flush and start together in IDLE: flush wins, nothing is fetched.
        flush_a = 1'b1;
        start_a = 1'b1;
        tick();
        flush_a = 1'b0;
        start_a = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_a.instr_valid !== 1'b0 || bus_a.instruction_address !== 5'd0) begin
            errors++;
            $display("FAIL flush_vs_start: valid=%b addr=%0d required valid=0 addr=0", bus_a.instr_valid, bus_a.instruction_address);
        end
        bus_a.instr_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!(bus_a.instr_valid === 1'b1 && bus_a.instruction_address === 5'd6) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL flush_reach: address 5 never presented within %0d cycles", n);
        end
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        checks++;
        if (bus_a.instr_valid !== 1'b0 || bus_a.instruction_address !== 5'd0 || halted_a !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: valid=%b addr=%0d halted=%b required 0/0/0",
                     bus_a.instr_valid, bus_a.instruction_address, halted_a);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_a.instr_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_quiet: instr_valid rose without start, required 0");
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        checks++;
        if (bus_a.instr_valid !== 1'b1 || {bus_a.opcode, bus_a.reg_sel, bus_a.operand} !== mem_a[0]) begin
            errors++;
            $display("FAIL flush_restart: valid=%b fields=%h required valid=1 fields=%h",
                     bus_a.instr_valid, {bus_a.opcode, bus_a.reg_sel, bus_a.operand}, mem_a[0]);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        for (int a = 0; a < 32; a++) mem_a[a] = rand_word(0);
        mem_a[0] = 16'h1234;
        bus_a.instr_ready = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (bus_a.instr_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (bus_a.instr_valid !== 1'b1 || {bus_a.opcode, bus_a.reg_sel, bus_a.operand} !== 16'h1234) begin
            errors++;
            $display("FAIL areset_setup: valid=%b fields=%h required valid=1 fields=1234",
                     bus_a.instr_valid, {bus_a.opcode, bus_a.reg_sel, bus_a.operand});
        end
        bus_a.instr_ready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_a.instr_valid, halted_a, bus_a.instruction_address, bus_a.opcode, bus_a.reg_sel, bus_a.operand} !== 24'd0) begin
            errors++;
            $display("FAIL areset_now: outputs %h required 0",
                     {bus_a.instr_valid, halted_a, bus_a.instruction_address, bus_a.opcode, bus_a.reg_sel, bus_a.operand});
        end
        #1;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_a.instr_valid !== 1'b0 || bus_a.instruction_address !== 5'd0 || bus_a.opcode !== 4'd0) begin
            errors++;
            $display("FAIL areset_after: valid=%b addr=%0d opcode=%h required 0/0/0",
                     bus_a.instr_valid, bus_a.instruction_address, bus_a.opcode);
        end
    endtask

    initial begin
        test_reset();
        test_first_valid();
        test_stall();
        test_full_run();
        test_last_addr();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter LAST_ADDR, default 31, giving the highest program address fetched before halting.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  begins fetching from IDLE, or restarts from HALT.
REQ-006 flush  input  1  synchronous abort: return to IDLE with pc=0.
REQ-007 instruction_address  output  5  program-memory address, equal to pc.
REQ-008 instruction  input  16  combinational program-memory read data for instruction_address.
REQ-009 instr_valid  output  1  decoded instruction fields are valid.
REQ-010 instr_ready  input  1  downstream accepts the presented instruction.
REQ-011 opcode  output  4  instruction register bits [15:12].
REQ-012 reg_sel  output  2  instruction register bits [11:10].
REQ-013 operand  output  10  instruction register bits [9:0].
REQ-014 halted  output  1  program end reached.

Function
REQ-015 The FSM SHALL have four states: IDLE, FETCH, PRESENT and HALT.
REQ-016 IDLE: start=1 -> FETCH; otherwise remain in IDLE; instr_valid=0.
REQ-017 FETCH: on the clock edge, the 16-bit instruction SHALL be captured into the instruction register, last_flag<=(pc==LAST_ADDR), pc<=pc+1 (5-bit wrap), state -> PRESENT.
REQ-018 PRESENT: instr_valid=1, and opcode/reg_sel/operand SHALL remain stable until the cycle where instr_valid&&instr_ready.
REQ-019 On handshake, the next state SHALL be HALT if last_flag=1, else FETCH; no handshake -> remain in PRESENT.
REQ-020 Throughput SHALL be one instruction per two cycles when instr_ready is held high; latency is start to first instr_valid = 2 cycles.
REQ-021 HALT: halted=1, instr_valid=0; start=1 -> pc<=0, halted<=0, state -> FETCH.
REQ-022 flush=1 SHALL take priority over start and handshake in every state: next state IDLE, pc<=0, instr_valid=0, halted=0; an instruction presented in the same cycle is dropped even if instr_ready=1.
REQ-023 start SHALL be ignored in FETCH and PRESENT.
REQ-024 Wrap-around: with LAST_ADDR=31, pc SHALL go 31->0 on the final fetch, and HALT is entered after that instruction is accepted.
REQ-025 halted and instr_valid SHALL never both be 1.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, pc=0, last_flag=0, instruction register=0, instr_valid=0, and halted=0.
REQ-027 Reset mid-handshake SHALL drop the presented instruction; no partial state may be retained after rst deasserts.

Configuration
REQ-028 Macro FETCH_NOP_SKIP_EN SHALL control NOP skipping.
REQ-029 With FETCH_NOP_SKIP_EN defined, a fetched opcode 4'b1111 (NOP) SHALL NOT be captured: pc still increments, and the FSM stays in FETCH, or goes to HALT if pc==LAST_ADDR. Consecutive NOPs cost one cycle each.
REQ-030 Without FETCH_NOP_SKIP_EN, NOP SHALL be presented like any other opcode.

Verification
REQ-031 Reset, start, instr_ready=1, memory with address 0 = 16'hF000 and address 1 = 16'h0000 -> first valid shows opcode 4'hF (macro off) or opcode 4'h0 from address 1 (macro on).
REQ-032 instr_ready=0 for 5 cycles while in PRESENT -> instr_valid stays 1 and the fields are unchanged; pc stays 1 ahead of the presented address.
REQ-033 LAST_ADDR=3, run to the end -> exactly 4 handshakes, then halted=1, instruction_address=4; start -> address 0 is fetched again.
REQ-034 flush asserted in the same cycle as instr_valid&&instr_ready at address 5 -> state IDLE, pc=0, and no further valid until start.
REQ-035 rst pulsed asynchronously between clock edges during PRESENT -> all outputs read 0 immediately.
REQ-036 LAST_ADDR=31, full run with instr_ready=1 -> 32 handshakes in 64 cycles after start, then pc=0 and halted=1.
